// File: rtl/trap_sequencer.sv
// Trap/return sequencer: picks one winner among sync exceptions, xRET and interrupts, drains the pipeline,
// then strobes the CSR commit and front-end redirect. Optional macro TRAP_IRQ_SYNC_EN synchronizes irq lines.
module trap_sequencer #(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            m_interrupt,
    input  logic            s_interrupt,
    input  logic            u_interrupt,
    input  logic            m_timer,
    input  logic            s_timer,
    input  logic            u_timer,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    input  logic            u_eie,
    input  logic            u_tie,
    input  logic            u_sie,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            m_ret_in,
    input  logic            s_ret_in,
    input  logic            u_ret_in,
    input  logic [XLEN-1:0] int_pc,
    input  logic            pipe_idle,
    output logic            stall_req,
    output logic            flush,
    output logic            exception_pending,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            s_ret,
    output logic            u_ret,
    output logic            redirect,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_t;

    localparam int            CW       = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      ret_q, ret_d;

    logic m_irq, s_irq, u_irq;

`ifdef TRAP_IRQ_SYNC_EN
    logic [1:0] m_sync, s_sync, u_sync;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            m_sync <= '0;
            s_sync <= '0;
            u_sync <= '0;
        end else begin
            m_sync <= {m_sync[0], m_interrupt};
            s_sync <= {s_sync[0], s_interrupt};
            u_sync <= {u_sync[0], u_interrupt};
        end
    end

    assign m_irq = m_sync[1];
    assign s_irq = s_sync[1];
    assign u_irq = u_sync[1];
`else
    assign m_irq = m_interrupt;
    assign s_irq = s_interrupt;
    assign u_irq = u_interrupt;
`endif

    logic            irq_any;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;
    logic [2:0]      ret_sel;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        irq_any  = 1'b1;
        irq_code = 4'd0;
        if      (m_irq   && m_eie) irq_code = 4'd11;
        else if (m_timer && m_tie) irq_code = 4'd7;
        else if (s_irq   && s_eie) irq_code = 4'd9;
        else if (s_timer && s_tie) irq_code = 4'd5;
        else if (u_irq   && u_eie) irq_code = 4'd8;
        else if (u_timer && u_tie) irq_code = 4'd4;
        else if (u_sie)            irq_code = 4'd0;
        else                       irq_any  = 1'b0;

        irq_cause            = '0;
        irq_cause[XLEN-1]    = 1'b1;
        irq_cause[3:0]       = irq_code;

        if      (m_ret_in) ret_sel = 3'b100;
        else if (s_ret_in) ret_sel = 3'b010;
        else if (u_ret_in) ret_sel = 3'b001;
        else               ret_sel = 3'b000;
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        cause_d           = cause_q;
        pc_d              = pc_q;
        ret_d             = ret_q;
        stall_req         = 1'b0;
        flush             = 1'b0;
        exception_pending = 1'b0;
        redirect          = 1'b0;

        // Outputs are held quiet while reset is asserted.
        if (nrst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (exc_valid) begin
                        cause_d   = exc_cause;
                        pc_d      = exc_pc;
                        ret_d     = 3'b000;
                        flush     = 1'b1;
                        stall_req = 1'b1;
                        state_d   = S_COMMIT;
                    end else if (ret_sel != 3'b000) begin
                        cause_d   = '0;
                        pc_d      = '0;
                        ret_d     = ret_sel;
                        flush     = 1'b1;
                        stall_req = 1'b1;
                        state_d   = S_COMMIT;
                    end else if (irq_any) begin
                        cause_d   = irq_cause;
                        pc_d      = int_pc;
                        ret_d     = 3'b000;
                        cnt_d     = '0;
                        stall_req = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    stall_req = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    // An older instruction faulting while we drain outranks the latched interrupt.
                    if (exc_valid) begin
                        cause_d = exc_cause;
                        pc_d    = exc_pc;
                        ret_d   = 3'b000;
                        flush   = 1'b1;
                        state_d = S_COMMIT;
                    end else if (pipe_idle || cnt_q == CNT_LAST) begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    exception_pending = 1'b1;
                    stall_req         = 1'b1;
                    state_d           = S_REDIRECT;
                end
                S_REDIRECT: begin
                    redirect  = 1'b1;
                    flush     = 1'b1;
                    stall_req = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments and a reset sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            pc_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign cause  = (state_q == S_COMMIT) ? cause_q : '0;
    assign pc_exc = (state_q == S_COMMIT) ? pc_q    : '0;
    assign m_ret  = (state_q == S_COMMIT) && ret_q[2];
    assign s_ret  = (state_q == S_COMMIT) && ret_q[1];
    assign u_ret  = (state_q == S_COMMIT) && ret_q[0];

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected commits are queued at stimulus time and checked on every
// exception_pending strobe; scenario tasks check timing, flush/stall/redirect and reset behaviour inline.
module tb_trap_sequencer;

    localparam int XLEN          = 32;
    localparam int DRAIN_TIMEOUT = 16;
`ifdef TRAP_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    // irq_vec bits: 12 m_int, 11 m_timer, 10 s_int, 9 s_timer, 8 u_int, 7 u_timer,
    //               6 m_eie, 5 m_tie, 4 s_eie, 3 s_tie, 2 u_eie, 1 u_tie, 0 u_sie
    localparam logic [12:0] LINES_MASK = 13'b1111110000000;
    localparam logic [12:0] PRIO_VEC [7] = '{
        13'b1001001001000,
        13'b0000000000001,
        13'b0110000110000,
        13'b0010111101111,
        13'b0001010001010,
        13'b0000010000011,
        13'b1000010010000
    };
    localparam int PRIO_CODE [7] = '{11, 0, 7, 8, 5, 4, -1};

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] pc;
        logic [2:0]      ret;
    } exp_t;

    logic            clk = 1'b0;
    logic            nrst;
    logic [12:0]     irq_vec;
    logic            exc_valid;
    logic [XLEN-1:0] exc_cause, exc_pc, int_pc;
    logic            m_ret_in, s_ret_in, u_ret_in;
    logic            pipe_idle;
    logic            stall_req, flush, exception_pending, redirect, busy;
    logic [XLEN-1:0] cause, pc_exc;
    logic            m_ret, s_ret, u_ret;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_pending = 1'b0;

    trap_sequencer #(.XLEN(XLEN), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
        .clk(clk), .nrst(nrst),
        .m_interrupt(irq_vec[12]), .s_interrupt(irq_vec[10]), .u_interrupt(irq_vec[8]),
        .m_timer(irq_vec[11]), .s_timer(irq_vec[9]), .u_timer(irq_vec[7]),
        .m_eie(irq_vec[6]), .m_tie(irq_vec[5]), .s_eie(irq_vec[4]), .s_tie(irq_vec[3]),
        .u_eie(irq_vec[2]), .u_tie(irq_vec[1]), .u_sie(irq_vec[0]),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .m_ret_in(m_ret_in), .s_ret_in(s_ret_in), .u_ret_in(u_ret_in),
        .int_pc(int_pc), .pipe_idle(pipe_idle),
        .stall_req(stall_req), .flush(flush), .exception_pending(exception_pending),
        .cause(cause), .pc_exc(pc_exc), .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
        .redirect(redirect), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard monitor: every commit strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exception_pending) begin
            checks++;
            if (prev_pending) begin
                errors++;
                $display("FAIL pending_width: exception_pending high two cycles in a row");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit: cause=%h pc=%h with no commit expected", cause, pc_exc);
            end else begin
                e = sb.pop_front();
                if ({cause, pc_exc, m_ret, s_ret, u_ret} !== e) begin
                    errors++;
                    $display("FAIL commit_value: got cause=%h pc=%h ret=%b%b%b want cause=%h pc=%h ret=%b",
                             cause, pc_exc, m_ret, s_ret, u_ret, e.cause, e.pc, e.ret);
                end
            end
        end else if ({cause, pc_exc, m_ret, s_ret, u_ret} !== '0) begin
            checks++;
            errors++;
            $display("FAIL idle_outputs: cause=%h pc=%h ret=%b%b%b outside commit",
                     cause, pc_exc, m_ret, s_ret, u_ret);
        end
        prev_pending = exception_pending;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pending(input int budget, output int cyc);
        cyc = -1;
        for (int c = 0; c < budget && cyc < 0; c++) begin
            @(negedge clk);
            if (exception_pending) cyc = c;
        end
    endtask

    task automatic finish_seq;
        step;
        irq_vec   = '0;
        exc_valid = 1'b0;
        pipe_idle = 1'b1;
        @(negedge clk);
        step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b0; irq_vec = '0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; int_pc = '0;
        m_ret_in = 1'b0; s_ret_in = 1'b0; u_ret_in = 1'b0; pipe_idle = 1'b1;
        step;
        step;
        @(negedge clk);
        checks++;
        if ({stall_req, flush, exception_pending, redirect, busy, cause, pc_exc, m_ret, s_ret, u_ret} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b flush=%b pend=%b redir=%b busy=%b cause=%h pc=%h want all 0",
                     stall_req, flush, exception_pending, redirect, busy, cause, pc_exc);
        end
        step;
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exception;
        step;
        exc_valid = 1'b1; exc_cause = 32'h2; exc_pc = 32'h100;
        sb.push_back({32'h2, 32'h100, 3'b000});
        @(negedge clk);
        checks++;
        if ({flush, stall_req, busy} !== 3'b110) begin
            errors++;
            $display("FAIL exc_accept: flush/stall/busy=%b want 110", {flush, stall_req, busy});
        end
        step;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
        @(negedge clk);
        checks++;
        if (exception_pending !== 1'b1) begin
            errors++;
            $display("FAIL exc_commit: exception_pending=%b want 1 at N+1", exception_pending);
        end
        step;
        @(negedge clk);
        checks++;
        if ({redirect, flush, stall_req, busy} !== 4'b1111) begin
            errors++;
            $display("FAIL exc_redirect: redir/flush/stall/busy=%b want 1111", {redirect, flush, stall_req, busy});
        end
        step;
        @(negedge clk);
        checks++;
        if ({busy, redirect, stall_req, flush} !== 4'b0000) begin
            errors++;
            $display("FAIL exc_idle: busy/redir/stall/flush=%b want 0000", {busy, redirect, stall_req, flush});
        end
    endtask

    task automatic test_timer_drain;
        step;
        irq_vec = 13'b0100000100000; int_pc = 32'h200; pipe_idle = 1'b0;
        sb.push_back({32'h8000_0007, 32'h200, 3'b000});
        @(negedge clk);
        checks++;
        if ({stall_req, flush, busy} !== 3'b100) begin
            errors++;
            $display("FAIL irq_accept: stall/flush/busy=%b want 100", {stall_req, flush, busy});
        end
        step;
        irq_vec = '0;
        for (int d = 1; d <= 3; d++) begin
            if (d == 3) pipe_idle = 1'b1;
            @(negedge clk);
            checks++;
            if ({busy, stall_req, flush, exception_pending} !== 4'b1100) begin
                errors++;
                $display("FAIL drain_hold: cycle %0d busy/stall/flush/pend=%b want 1100", d,
                         {busy, stall_req, flush, exception_pending});
            end
            step;
        end
        @(negedge clk);
        checks++;
        if (exception_pending !== 1'b1) begin
            errors++;
            $display("FAIL drain_commit: exception_pending=%b want 1 after 3 drain cycles", exception_pending);
        end
        finish_seq;
    endtask

    task automatic test_priority;
        int cyc;
        for (int i = 0; i < 7; i++) begin
            step;
            irq_vec = PRIO_VEC[i] & LINES_MASK;
            int_pc  = 32'h400 + 32'(i * 4);
            repeat (SYNC_LAT) step;
            irq_vec = PRIO_VEC[i];
            if (PRIO_CODE[i] >= 0) begin
                sb.push_back({32'h8000_0000 | 32'(PRIO_CODE[i]), int_pc, 3'b000});
                wait_pending(20, cyc);
                checks++;
                if (cyc !== 2) begin
                    errors++;
                    $display("FAIL prio_latency: entry %0d commit at N+%0d want N+2", i, cyc);
                end
                finish_seq;
            end else begin
                repeat (3) @(negedge clk);
                checks++;
                if ({busy, stall_req} !== 2'b00) begin
                    errors++;
                    $display("FAIL prio_gated: entry %0d busy/stall=%b want 00", i, {busy, stall_req});
                end
                step;
                irq_vec = '0;
                repeat (3) @(negedge clk);
            end
        end
    endtask

    task automatic test_irq_latency;
        int cyc;
        step;
        irq_vec = 13'b1000001000000; int_pc = 32'h500; pipe_idle = 1'b1;
        sb.push_back({32'h8000_000B, 32'h500, 3'b000});
        wait_pending(20, cyc);
        checks++;
        if (cyc !== 2 + SYNC_LAT) begin
            errors++;
            $display("FAIL irq_latency: commit at N+%0d want N+%0d", cyc, 2 + SYNC_LAT);
        end
        finish_seq;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_exc_in_drain;
        step;
        irq_vec = 13'b0100000100000; int_pc = 32'h600; pipe_idle = 1'b0;
        sb.push_back({32'h4, 32'h1F0, 3'b000});
        step;
        irq_vec = '0;
        @(negedge clk);
        step;
        exc_valid = 1'b1; exc_cause = 32'h4; exc_pc = 32'h1F0;
        @(negedge clk);
        checks++;
        if ({flush, stall_req, exception_pending} !== 3'b110) begin
            errors++;
            $display("FAIL drain_exc_flush: flush/stall/pend=%b want 110", {flush, stall_req, exception_pending});
        end
        step;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; pipe_idle = 1'b1;
        @(negedge clk);
        checks++;
        if (exception_pending !== 1'b1) begin
            errors++;
            $display("FAIL drain_exc_commit: exception_pending=%b want 1", exception_pending);
        end
        finish_seq;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc;
        step;
        irq_vec = 13'b0100000100000; int_pc = 32'h700; pipe_idle = 1'b0;
        sb.push_back({32'h8000_0007, 32'h700, 3'b000});
        wait_pending(40, cyc);
        checks++;
        if (cyc !== 1 + DRAIN_TIMEOUT) begin
            errors++;
            $display("FAIL drain_timeout: commit at N+%0d want N+%0d", cyc, 1 + DRAIN_TIMEOUT);
        end
        finish_seq;
    endtask

    task automatic test_reset_drain;
        step;
        irq_vec = 13'b0100000100000; int_pc = 32'h800; pipe_idle = 1'b0;
        step;
        irq_vec = '0;
        @(negedge clk);
        step;
        nrst = 1'b0;
        @(negedge clk);
        step;
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_req, flush, exception_pending, redirect, busy, cause, pc_exc, m_ret, s_ret, u_ret} !== '0) begin
            errors++;
            $display("FAIL reset_drain: stall=%b flush=%b pend=%b redir=%b busy=%b want all 0",
                     stall_req, flush, exception_pending, redirect, busy);
        end
        pipe_idle = 1'b1;
        repeat (DRAIN_TIMEOUT + 4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_xret;
        logic [2:0] ins  [2] = '{3'b110, 3'b001};
        logic [2:0] outs [2] = '{3'b100, 3'b001};
        for (int i = 0; i < 2; i++) begin
            step;
            {m_ret_in, s_ret_in, u_ret_in} = ins[i];
            exc_pc = 32'h123; int_pc = 32'h456;
            sb.push_back({32'h0, 32'h0, outs[i]});
            @(negedge clk);
            checks++;
            if ({flush, stall_req} !== 2'b11) begin
                errors++;
                $display("FAIL xret_accept: case %0d flush/stall=%b want 11", i, {flush, stall_req});
            end
            step;
            {m_ret_in, s_ret_in, u_ret_in} = 3'b000;
            @(negedge clk);
            checks++;
            if (exception_pending !== 1'b1) begin
                errors++;
                $display("FAIL xret_commit: case %0d exception_pending=%b want 1", i, exception_pending);
            end
            finish_seq;
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        step;
        exc_valid = 1'b1; exc_cause = 32'hD; exc_pc = 32'h800;
        sb.push_back({32'hD, 32'h800, 3'b000});
        sb.push_back({32'hD, 32'h900, 3'b000});
        wait_pending(10, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL b2b_first: commit at N+%0d want N+1", cyc);
        end
        step;
        exc_pc = 32'h900;
        @(negedge clk);
        checks++;
        if ({redirect, flush} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_redirect: redir/flush=%b want 11", {redirect, flush});
        end
        step;
        @(negedge clk);
        checks++;
        if ({busy, flush, stall_req} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_resample: busy/flush/stall=%b want 011", {busy, flush, stall_req});
        end
        step;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
        @(negedge clk);
        checks++;
        if (exception_pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: exception_pending=%b want 1", exception_pending);
        end
        finish_seq;
    endtask

    initial begin
        test_reset;
        test_exception;
        test_timer_drain;
        test_priority;
        test_irq_latency;
        test_exc_in_drain;
        test_timeout;
        test_reset_drain;
        test_xret;
        test_back_to_back;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected commits never seen, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
